wptr_full_sync: RTL
===================

WPTR_FULL_SYNC -- requirements
Module: wptr_full_sync

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, meaning FIFO depth = 2^ADDRSIZE entries.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning number of synchroniser flops for rptr; legal range 2..4.
REQ-003 SHALL have parameter AFULL_THRESH, default 2^ADDRSIZE-2, meaning the fill level at or above which walmost_full asserts; legal range 1..2^ADDRSIZE.
REQ-004 SHALL have port wclk, input, 1, write-domain clock, rising edge.
REQ-005 SHALL have port wrst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port winc, input, 1, write request.
REQ-007 SHALL have port rptr, input, ADDRSIZE+1, Gray-coded read pointer from the read clock domain.
REQ-008 SHALL have port waddr, output, ADDRSIZE, binary write address to the memory.
REQ-009 SHALL have port wptr, output, ADDRSIZE+1, registered Gray-coded write pointer for the read domain.
REQ-010 SHALL have port wq_rptr, output, ADDRSIZE+1, rptr after SYNC_STAGES synchroniser flops.
REQ-011 SHALL have port wfull, output, 1, FIFO full, registered.
REQ-012 SHALL have port walmost_full, output, 1, fill level >= AFULL_THRESH, registered.
REQ-013 SHALL have port wlevel, output, ADDRSIZE+1, fill level 0..2^ADDRSIZE as seen by the write side, registered.
REQ-014 SHALL have port wptr_err, output, 1, sticky synchronised-pointer integrity error.

Function
REQ-015 Synchroniser: rptr SHALL pass through SYNC_STAGES cascaded wclk flops; wq_rptr SHALL be the last stage; there SHALL be no logic between stages.
REQ-016 Write pointer: an internal (ADDRSIZE+1)-bit binary counter wbin SHALL increment by 1 on a wclk edge when winc=1 and wfull=0, and SHALL wrap from 2^(ADDRSIZE+1)-1 to 0.
REQ-017 winc=1 while wfull=1 SHALL be ignored: no pointer, level or flag change.
REQ-018 The write address waddr SHALL equal wbin[ADDRSIZE-1:0].
REQ-019 wptr SHALL be registered as wgraynext = (wbinnext>>1) XOR wbinnext, so consecutive wptr values differ in exactly one bit.
REQ-020 wq_rptr SHALL be converted Gray-to-binary combinationally as rbin_s, an XOR prefix from the MSB down.
REQ-021 wfull SHALL be registered as (wgraynext == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]}).
REQ-022 wlevel SHALL be registered as (wbinnext - rbin_s) modulo 2^(ADDRSIZE+1).
REQ-023 walmost_full SHALL be registered as (wbinnext - rbin_s) >= AFULL_THRESH.
REQ-024 Latency: a write SHALL update waddr, wptr, wlevel, walmost_full and wfull on the same wclk edge that accepts it.
REQ-025 Latency: a change on rptr SHALL reach wq_rptr after SYNC_STAGES edges, and SHALL reach wfull, walmost_full and wlevel one edge later (SYNC_STAGES+1 total).
REQ-026 Simultaneous write and read-pointer advance SHALL leave wlevel unchanged once the read update has propagated; both effects SHALL apply independently.
REQ-027 Flags are pessimistic: wfull SHALL never deassert before the synchronised rptr shows free space.
REQ-028 wptr_err SHALL set on the edge after wq_rptr changes in more than one bit between consecutive cycles.
REQ-029 wptr_err SHALL also set on the edge after the computed level exceeds 2^ADDRSIZE.
REQ-030 wptr_err SHALL remain set until reset; it SHALL NOT block writes.
REQ-031 Pointer wrap: full detection and level SHALL be correct across wbin and rbin_s wrap, because the MSB wrap bit is distinguished.

Reset
REQ-032 On wrst_n=0, all synchroniser stages, wbin, wptr, wq_rptr, wlevel, wfull, walmost_full and wptr_err SHALL go to 0 asynchronously, without waiting for wclk.
REQ-033 Reset deassertion SHALL be sampled on wclk; the first write SHALL be accepted on the first edge with wrst_n=1 and winc=1.
REQ-034 Reset mid-operation SHALL discard all pointer state; the block SHALL behave as empty thereafter.

Verification
REQ-035 Reset then 16 writes with rptr=0 (ADDRSIZE=4, default parameters): wlevel counts 1..16, walmost_full=1 from the 14th write, wfull=1 after the 16th, wptr=5'b11000.
REQ-036 From full, drive a 17th winc: waddr, wptr and wlevel stay unchanged and wfull stays 1.
REQ-037 From full, step rptr to Gray 5'b00001: wq_rptr=00001 after 2 edges; wfull=0 and wlevel=15 on the 3rd edge; with SYNC_STAGES=3, on the 4th edge.
REQ-038 Wrap test: 40 writes interleaved with rptr advancing in Gray, keeping level at 4: wlevel stays 4 through the wbin wrap 31->0 and wfull never asserts.
REQ-039 Drive rptr from 00000 to 00011 in one step (two-bit change): wptr_err=1 one edge after wq_rptr changes; it stays 1 under continued writes and clears only on wrst_n=0.
REQ-040 Assert wrst_n=0 between clock edges with level=9: all outputs read 0 before the next wclk edge; after release, one write gives wlevel=1 and waddr=1.

Source files
------------

// File: rtl/wptr_full_sync.sv
// Write-side half of an asynchronous FIFO.
// Synchronises the Gray-coded read pointer into wclk and keeps the binary and
// Gray write pointers. From these it derives the registered full, almost-full
// and fill-level flags, plus a sticky pointer-integrity error.
//
// Ports:
//   wclk         in   write clock, rising edge
//   wrst_n       in   asynchronous active-low reset
//   winc         in   write request (ignored while wfull=1)
//   rptr         in   Gray read pointer from the read domain (ADDRSIZE+1)
//   waddr        out  binary write address to the memory (ADDRSIZE)
//   wptr         out  registered Gray write pointer to the read domain
//   wq_rptr      out  rptr after SYNC_STAGES synchroniser flops
//   wfull        out  FIFO full, registered
//   walmost_full out  fill level >= AFULL_THRESH, registered
//   wlevel       out  fill level 0..2^ADDRSIZE seen by the write side
//   wptr_err     out  sticky synchronised-pointer integrity error
module wptr_full_sync #(
  parameter int ADDRSIZE     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   wq_rptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wptr_err
);

  localparam logic [ADDRSIZE:0] AFULL_C = (ADDRSIZE+1)'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] DEPTH_C = {1'b1, {ADDRSIZE{1'b0}}};

  // Binary to Gray.
  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Gray to binary: XOR prefix from the MSB downwards.
  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit is set (a legal Gray step flips at most one).
  function automatic logic multi_bit(input logic [ADDRSIZE:0] d);
    return (d & (d - (ADDRSIZE+1)'(1))) != {(ADDRSIZE+1){1'b0}};
  endfunction

  logic [ADDRSIZE:0] sync_r [SYNC_STAGES];
  logic [ADDRSIZE:0] wq_prev_r;
  logic [ADDRSIZE:0] wbin_r;
  logic [ADDRSIZE:0] wptr_r;
  logic [ADDRSIZE:0] wlevel_r;
  logic              wfull_r;
  logic              walmost_full_r;
  logic              wptr_err_r;

  logic              winc_ok_s;
  logic [ADDRSIZE:0] wq_rptr_s;
  logic [ADDRSIZE:0] wbinnext_s;
  logic [ADDRSIZE:0] wgraynext_s;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_s;
  logic              full_next_s;
  logic              afull_next_s;
  logic              err_next_s;

  assign wq_rptr_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain for the read pointer: plain flops, no logic between.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {(ADDRSIZE+1){1'b0}};
      end
    end else begin
      sync_r[0] <= rptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Next-state pointer arithmetic and flag computation.
  always_comb begin
    winc_ok_s    = winc & ~wfull_r;
    wbinnext_s   = wbin_r + {{ADDRSIZE{1'b0}}, winc_ok_s};
    wgraynext_s  = bin2gray(wbinnext_s);
    rbin_s       = gray2bin(wq_rptr_s);
    // Modulo 2^(ADDRSIZE+1) subtraction keeps the level right across wraps.
    level_s      = wbinnext_s - rbin_s;
    // Full: pointers equal except the two MSBs inverted (one lap ahead).
    full_next_s  = (wgraynext_s == {~wq_rptr_s[ADDRSIZE:ADDRSIZE-1],
                                    wq_rptr_s[ADDRSIZE-2:0]});
    afull_next_s = (level_s >= AFULL_C);
    err_next_s   = wptr_err_r
                 | multi_bit(wq_rptr_s ^ wq_prev_r)
                 | (level_s > DEPTH_C);
  end

  // Pointer, flag and error registers; all flags follow the same edge.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq_prev_r      <= {(ADDRSIZE+1){1'b0}};
      wbin_r         <= {(ADDRSIZE+1){1'b0}};
      wptr_r         <= {(ADDRSIZE+1){1'b0}};
      wlevel_r       <= {(ADDRSIZE+1){1'b0}};
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      wptr_err_r     <= 1'b0;
    end else begin
      wq_prev_r      <= wq_rptr_s;
      wbin_r         <= wbinnext_s;
      wptr_r         <= wgraynext_s;
      wlevel_r       <= level_s;
      wfull_r        <= full_next_s;
      walmost_full_r <= afull_next_s;
      wptr_err_r     <= err_next_s;
    end
  end

  assign waddr        = wbin_r[ADDRSIZE-1:0];
  assign wptr         = wptr_r;
  assign wq_rptr      = wq_rptr_s;
  assign wfull        = wfull_r;
  assign walmost_full = walmost_full_r;
  assign wlevel       = wlevel_r;
  assign wptr_err     = wptr_err_r;

endmodule
